// File: rtl/alu_sequencer.sv
// RV32I integer ALU issue/decode stage driving a 3-bit-opcode ALU32.
// Multi-bit shifts are sequenced as repeated single-bit ALU shifts.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_in0,
    output logic [31:0] alu_in1,
    output logic [2:0]  alu_op,
    input  logic [30:0] alu_out,
    input  logic        alu_of,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  rd,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t      state, state_nxt;
    logic [31:0] work;
    logic [31:0] b_reg;
    logic [2:0]  op_reg;
    logic [4:0]  cnt;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_r, is_i;
    logic        dec_legal, dec_shift;
    logic [2:0]  dec_op;
    logic [31:0] dec_b;
    logic [4:0]  dec_n;
    logic        accept;
    logic        lt;
    logic [31:0] assembled;
    logic        unused_bits;

    assign opc         = instr[6:0];
    assign f3          = instr[14:12];
    assign f7          = instr[31:25];
    assign is_r        = (opc == OPC_R);
    assign is_i        = (opc == OPC_I);
    assign unused_bits = ^instr[19:15];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        dec_legal = 1'b0;
        dec_shift = 1'b0;
        dec_op    = 3'd0;
        dec_b     = is_r ? rs2_val : {{20{instr[31]}}, instr[31:20]};
        dec_n     = is_r ? rs2_val[4:0] : instr[24:20];
        if (is_r || is_i) begin
            case (f3)
                3'b000: begin
                    if (is_i || f7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                        dec_op    = 3'd2;
                    end else if (f7 == F7_ALT) begin
                        dec_legal = 1'b1;
                        dec_op    = 3'd3;
                    end
                end
                3'b111: begin
                    dec_legal = is_i || (f7 == F7_ZERO);
                    dec_op    = 3'd0;
                end
                3'b110: begin
                    dec_legal = is_i || (f7 == F7_ZERO);
                    dec_op    = 3'd1;
                end
                3'b010: begin
                    dec_legal = is_i || (f7 == F7_ZERO);
                    dec_op    = 3'd4;
                end
                // shift immediates carry funct7 in the immediate field, so both forms check it
                3'b001: begin
                    dec_legal = (f7 == F7_ZERO);
                    dec_shift = 1'b1;
                    dec_op    = 3'd7;
                end
                3'b101: begin
                    dec_legal = (f7 == F7_ZERO);
                    dec_shift = 1'b1;
                    dec_op    = 3'd6;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        alu_in0 = '0;
        alu_in1 = '0;
        alu_op  = 3'd0;
        case (state)
            EXEC: begin
                alu_in0 = work;
                alu_in1 = b_reg;
                alu_op  = op_reg;
            end
            SHIFT: begin
                alu_in0 = work;
                alu_op  = op_reg;
            end
            default: ;
        endcase
    end

    // the ALU only returns bits [30:0]; bit 31 is rebuilt here per opcode
    assign lt = (work[31] ^ b_reg[31]) ? work[31] : alu_of;

    always_comb begin
        case (op_reg)
            3'd0:    assembled = {work[31] & b_reg[31], alu_out};
            3'd1:    assembled = {work[31] | b_reg[31], alu_out};
            3'd2,
            3'd3:    assembled = {alu_of, alu_out};
            3'd4:    assembled = {31'b0, lt};
            3'd7:    assembled = {work[30], alu_out};
            default: assembled = {1'b0, alu_out};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!dec_legal)
                        state_nxt = DONE;
                    else if (dec_shift && dec_n != 5'd0)
                        state_nxt = SHIFT;
                    else
                        state_nxt = EXEC;
                end
            end
            EXEC:  state_nxt = DONE;
            SHIFT: if (cnt == 5'd1) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            work    <= '0;
            b_reg   <= '0;
            op_reg  <= 3'd0;
            cnt     <= 5'd0;
            result  <= '0;
            rd      <= 5'd0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rd      <= instr[11:7];
                        illegal <= !dec_legal;
                        result  <= '0;
                        work    <= rs1_val;
                        // zero-length shift becomes an OR with zero to pass rs1 through
                        b_reg   <= dec_shift ? '0 : dec_b;
                        op_reg  <= (dec_shift && dec_n == 5'd0) ? 3'd1 : dec_op;
                        cnt     <= dec_shift ? dec_n : 5'd0;
                    end
                end
                EXEC: result <= assembled;
                SHIFT: begin
                    work <= assembled;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        result <= assembled;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: combinational ALU32 model, instruction-level
// reference model, directed cases pinned to literals and randomized traffic.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [2:0]  alu_op;
    logic [30:0] alu_out;
    logic        alu_of;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic        pending = 1'b0;
    int          acc_cyc = 0;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_ill;
    int          e_lat;
    logic [2:0]  e_sop;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
        .alu_out(alu_out), .alu_of(alu_of),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [31:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_op)
            3'd0: alu_full = alu_in0 & alu_in1;
            3'd1: alu_full = alu_in0 | alu_in1;
            3'd2: alu_full = alu_in0 + alu_in1;
            3'd3: alu_full = alu_in0 - alu_in1;
            3'd4: alu_full = alu_in0 - alu_in1;
            3'd5: alu_full = ~(alu_in0 | alu_in1);
            3'd6: alu_full = alu_in0 >> 1;
            3'd7: alu_full = alu_in0 << 1;
            default: alu_full = '0;
        endcase
    end
    assign alu_out = alu_full[30:0];
    assign alu_of  = (alu_op == 3'd2 || alu_op == 3'd3 || alu_op == 3'd4) ? alu_full[31] : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
        return {f7, 5'd2, 5'd1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] d);
        return {imm, 5'd1, f3, d, 7'b0010011};
    endfunction

    // Instruction-level reference: what RV32I says the answer is, plus the expected latency.
    function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b2,
                                  output logic [31:0] res, output logic ill,
                                  output int lat, output logic [2:0] sop);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] bv;
        logic [4:0]  sh;
        logic        isr, isi, ok, shift;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        isr = (opc == 7'b0110011);
        isi = (opc == 7'b0010011);
        bv  = isr ? b2 : {{20{ins[31]}}, ins[31:20]};
        sh  = bv[4:0];
        ok = 1'b0; shift = 1'b0; res = '0; sop = 3'd0;
        if (isr || isi) begin
            case (f3)
                3'b000: if (isi || f7 == 7'h00) begin ok = 1; res = a + bv; end
                        else if (f7 == 7'h20) begin ok = 1; res = a - bv; end
                3'b111: if (isi || f7 == 7'h00) begin ok = 1; res = a & bv; end
                3'b110: if (isi || f7 == 7'h00) begin ok = 1; res = a | bv; end
                3'b010: if (isi || f7 == 7'h00) begin ok = 1; res = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0; end
                3'b001: if (f7 == 7'h00) begin ok = 1; shift = 1; res = a << sh; sop = 3'd7; end
                3'b101: if (f7 == 7'h00) begin ok = 1; shift = 1; res = a >> sh; sop = 3'd6; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            res = '0;
            sop = 3'd0;
        end
        if (shift && sh == 5'd0) sop = 3'd0;
        ill = !ok;
        lat = !ok ? 0 : ((shift && sh != 5'd0) ? int'(sh) : 1);
    endfunction

    // Per-cycle compare against the outstanding transaction.
    int lat_seen_for = -1;
    always @(negedge clk) begin
        if (rst_n && pending) begin
            if (out_valid) begin
                if (lat_seen_for != acc_cyc) begin
                    chk("latency", cyc - acc_cyc, e_lat);
                    lat_seen_for = acc_cyc;
                end
                chk("result", result, e_res);
                chk("rd", {27'b0, rd}, {27'b0, e_rd});
                chk("illegal", {31'b0, illegal}, {31'b0, e_ill});
                chk("in_ready_done", {31'b0, in_ready}, 32'd0);
            end else begin
                chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
                if (e_sop != 3'd0) begin
                    chk("shift_op", {29'b0, alu_op}, {29'b0, e_sop});
                    chk("shift_in1", alu_in1, 32'd0);
                end
            end
        end
    end

    task automatic offer(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        int k;
        @(posedge clk); #1;
        instr = ins; rs1_val = a; rs2_val = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        model(ins, a, b, e_res, e_ill, e_lat, e_sop);
        e_rd = ins[11:7];
        instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
        pending = 1'b1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int hold);
        int k;
        offer(ins, a, b);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            chk("done_timeout", 32'd0, 32'd1);
            pending = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        pending = 1'b0;
        chk("release_valid", {31'b0, out_valid}, 32'd0);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic issue_lit(input string name, input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] b, input int hold, input logic [31:0] lit_res, input int lit_lat);
        logic [31:0] r;
        logic        il;
        int          l;
        logic [2:0]  so;
        model(ins, a, b, r, il, l, so);
        chk({name, "_pin_res"}, r, lit_res);
        chk({name, "_pin_lat"}, l, lit_lat);
        issue(ins, a, b, hold);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_rd"}, {27'b0, rd}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
        chk({tag, "_alu_in0"}, alu_in0, 32'd0);
        chk({tag, "_alu_in1"}, alu_in1, 32'd0);
        chk({tag, "_alu_op"}, {29'b0, alu_op}, 32'd0);
    endtask

    initial begin
        logic [31:0] ins, a, b;
        int kind;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        issue_lit("add",  enc_r(7'h00, 3'b000, 5'd3), 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 1);
        issue_lit("sub",  enc_r(7'h20, 3'b000, 5'd4), 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1);
        issue_lit("slti", enc_i(12'd1, 3'b010, 5'd5), 32'hFFFF_FFFF, 32'h0, 0, 32'd1, 1);
        issue_lit("slt",  enc_r(7'h00, 3'b010, 5'd6), 32'd1, 32'hFFFF_FFFF, 0, 32'd0, 1);
        issue_lit("slli", enc_i(12'd4, 3'b001, 5'd7), 32'd1, 32'h0, 0, 32'h0000_0010, 4);
        issue_lit("srl",  enc_r(7'h00, 3'b101, 5'd8), 32'h8000_0000, 32'd31, 0, 32'd1, 31);
        issue_lit("sll0", enc_r(7'h00, 3'b001, 5'd9), 32'h1234_5678, 32'h0000_0020, 0, 32'h1234_5678, 1);
        issue_lit("and",  enc_r(7'h00, 3'b111, 5'd10), 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hF000_F000, 1);
        issue_lit("or",   enc_r(7'h00, 3'b110, 5'd11), 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 32'hFFF0_FFF0, 1);
        issue_lit("load", {12'h004, 5'd1, 3'b010, 5'd12, 7'b0000011}, 32'h55, 32'h66, 0, 32'd0, 0);
        issue_lit("srai", enc_i({7'h20, 5'd3}, 3'b101, 5'd13), 32'h8000_0000, 32'h0, 0, 32'd0, 0);
        issue_lit("addi", enc_i(12'hFFF, 3'b000, 5'd14), 32'd5, 32'h0, 0, 32'd4, 1);
        issue_lit("hold", enc_r(7'h00, 3'b000, 5'd15), 32'd100, 32'd23, 5, 32'd123, 1);

        // asynchronous reset in the middle of a long shift
        offer(enc_i(12'd20, 3'b001, 5'd16), 32'h0000_0003, 32'h0);
        repeat (5) @(posedge clk);
        #3;
        pending = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue_lit("post_reset", enc_r(7'h00, 3'b000, 5'd17), 32'd40, 32'd2, 0, 32'd42, 1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case (kind)
                0: ins = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 3'b000, 5'($urandom));
                1: ins = enc_i(12'($urandom), 3'($urandom_range(0, 7)), 5'($urandom));
                2: ins = enc_r(7'h00, 3'b111, 5'($urandom));
                3: ins = enc_r(7'h00, 3'b110, 5'($urandom));
                4: ins = enc_r(7'h00, 3'b010, 5'($urandom));
                5: ins = enc_i({7'h00, 5'($urandom)}, 3'b001, 5'($urandom));
                6: ins = enc_r(7'h00, 3'b101, 5'($urandom));
                7: ins = enc_r(7'($urandom), 3'($urandom), 5'($urandom));
                8: ins = enc_i({7'h00, 5'($urandom)}, 3'b101, 5'($urandom));
                default: ins = $urandom;
            endcase
            issue(ins, a, b, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
